sobel_window_gen: RTL and testbench



---
 rtl/sobel_window_gen.sv | 105 ++++++++++
 tb/tb_sobel_window_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_gen.sv
// Builds 3x3 interior neighbourhood windows from a raster pixel stream,
// using two row buffers and a column shift window, with a valid/ready output.
module sobel_window_gen #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 16,
    parameter int IMG_HEIGHT  = 16
) (
    input  logic                     clk_i,
    input  logic                     nreset_i,
    input  logic                     clear_i,
    input  logic [PIXEL_WIDTH-1:0]   pixel_i,
    input  logic                     pixel_valid_i,
    output logic                     pixel_ready_o,
    output logic [9*PIXEL_WIDTH-1:0] window_o,
    output logic                     window_valid_o,
    input  logic                     window_ready_i,
    output logic                     frame_done_o
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [PIXEL_WIDTH-1:0] line0_q [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] line1_q [IMG_WIDTH];

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [8:0][PIXEL_WIDTH-1:0] win_q, win_d;
    logic valid_q, valid_d;
    logic done_q, done_d;
    logic acc, qualify;

    // Ready drops while a window waits unconsumed, so the window register
    // can never be overwritten under back-pressure.
    assign pixel_ready_o  = ~clear_i & (~valid_q | window_ready_i);
    assign acc            = pixel_valid_i & pixel_ready_o;
    assign qualify        = acc & (row_q >= ROW_TWO) & (col_q >= COL_TWO);
    assign window_o       = win_q;
    assign window_valid_o = valid_q;
    assign frame_done_o   = done_q;

    // NOTE: every signal gets its default first so no path leaves it unassigned (no latches).
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        valid_d = qualify | (valid_q & ~window_ready_i);
        done_d  = 1'b0;
        if (clear_i) begin
            col_d   = '0;
            row_d   = '0;
            valid_d = 1'b0;
        end else if (acc) begin
            // Shift each row left one column; the new right column is
            // {two rows up, one row up, incoming pixel}.
            win_d = {pixel_i, win_q[8:7], line0_q[col_q], win_q[5:4],
                     line1_q[col_q], win_q[2:1]};
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d  = '0;
                    done_d = 1'b1;
                end else begin
                    row_d = row_q + ROW_ONE;
                end
            end else begin
                col_d = col_q + COL_ONE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // NOTE: line buffers are deliberately not reset; every entry is written
    // in rows 0 and 1 before any qualifying window reads it.
    always_ff @(posedge clk_i) begin
        if (acc) begin
            line1_q[col_q] <= line0_q[col_q];
            line0_q[col_q] <= pixel_i;
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench: a 4x4 and a 16x16 instance driven from one stream,
// checked every cycle against an image-array reference model.
module tb_sobel_window_gen;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic clear = 1'b0;
    logic [7:0] pixel = '0;
    logic pvalid = 1'b0;
    logic wready = 1'b1;
    logic sel = 1'b0;

    logic pv_s, pr_s, wv_s, wr_s, fd_s;
    logic pv_b, pr_b, wv_b, wr_b, fd_b;
    logic [71:0] win_s, win_b;
    logic obs_pr, obs_wv, obs_fd;
    logic [71:0] obs_win;

    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign pv_s = pvalid & ~sel;
    assign pv_b = pvalid & sel;
    assign wr_s = wready & ~sel;
    assign wr_b = wready & sel;
    assign obs_pr  = sel ? pr_b : pr_s;
    assign obs_wv  = sel ? wv_b : wv_s;
    assign obs_fd  = sel ? fd_b : fd_s;
    assign obs_win = sel ? win_b : win_s;

    sobel_window_gen #(.PIXEL_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_small (
        .clk_i(clk), .nreset_i(nreset), .clear_i(clear), .pixel_i(pixel),
        .pixel_valid_i(pv_s), .pixel_ready_o(pr_s), .window_o(win_s),
        .window_valid_o(wv_s), .window_ready_i(wr_s), .frame_done_o(fd_s));

    sobel_window_gen #(.PIXEL_WIDTH(8), .IMG_WIDTH(16), .IMG_HEIGHT(16)) u_big (
        .clk_i(clk), .nreset_i(nreset), .clear_i(clear), .pixel_i(pixel),
        .pixel_valid_i(pv_b), .pixel_ready_o(pr_b), .window_o(win_b),
        .window_valid_o(wv_b), .window_ready_i(wr_b), .frame_done_o(fd_b));

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: the image received so far, indexed by (row, col);
    // a window is just the 3x3 block of that image ending at the new pixel.
    logic [7:0] img [0:15][0:15];
    int m_row, m_col;
    logic m_valid, m_done, m_acc, exp_pr;
    logic [71:0] m_win;
    int taken, done_cnt;

    always @(negedge clk) begin
        int w, h;
        w = sel ? 16 : 4;
        h = sel ? 16 : 4;
        if (!nreset) begin
            m_row = 0; m_col = 0; m_valid = 1'b0; m_done = 1'b0;
        end else begin
            check("window_valid", 72'(obs_wv), 72'(m_valid));
            if (m_valid) check("window_data", obs_win, m_win);
            check("frame_done", 72'(obs_fd), 72'(m_done));
            exp_pr = !clear && (!m_valid || wready);
            check("pixel_ready", 72'(obs_pr), 72'(exp_pr));
            if (obs_wv && wready) taken++;
            if (obs_fd) done_cnt++;
            m_acc = pvalid && exp_pr;
            if (clear) begin
                m_row = 0; m_col = 0; m_valid = 1'b0; m_done = 1'b0;
            end else begin
                m_done = m_acc && (m_row == h - 1) && (m_col == w - 1);
                if (m_valid && wready) m_valid = 1'b0;
                if (m_acc) begin
                    img[m_row][m_col] = pixel;
                    if (m_row >= 2 && m_col >= 2) begin
                        m_valid = 1'b1;
                        for (int i = 0; i < 3; i++)
                            for (int j = 0; j < 3; j++)
                                m_win[(3*i+j)*8 +: 8] = img[m_row-2+i][m_col-2+j];
                    end
                    m_col++;
                    if (m_col == w) begin
                        m_col = 0;
                        m_row++;
                        if (m_row == h) m_row = 0;
                    end
                end
            end
        end
    end

    // Ready behaviour: 0 = always ready, 1 = random, 2 = stall 5 cycles on first window.
    int rmode = 0;
    bit gaps = 0;
    int stall_cnt = 0;
    bit stall_done = 0;
    int cycles = 0;

    task automatic set_ready();
        case (rmode)
            1: wready = ($urandom_range(0, 3) != 0);
            2: begin
                if (!stall_done && obs_wv) begin
                    if (stall_cnt < 5) begin
                        wready = 1'b0;
                        stall_cnt++;
                    end else begin
                        wready = 1'b1;
                        stall_done = 1;
                    end
                end else begin
                    wready = 1'b1;
                end
            end
            default: wready = 1'b1;
        endcase
    endtask

    task automatic push_pixel(input logic [7:0] v);
        bit took = 0;
        int guard = 0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            pvalid = 1'b0;
            set_ready();
            @(posedge clk); #1;
        end
        pixel = v;
        pvalid = 1'b1;
        while (!took && guard < 50) begin
            set_ready();
            @(negedge clk);
            took = obs_pr;
            @(posedge clk); #1;
            guard++;
        end
        cycles += guard;
        if (!took) check("accept_budget", 72'(took), 72'(1));
    endtask

    task automatic idle(input int n);
        pvalid = 1'b0;
        rmode = 0;
        repeat (n) begin
            set_ready();
            @(posedge clk); #1;
        end
    endtask

    task automatic start_scn(input logic which);
        pvalid = 1'b0;
        clear = 1'b0;
        @(posedge clk); #1;
        nreset = 1'b0;
        sel = which;
        @(negedge clk);
        @(posedge clk); #1;
        nreset = 1'b1;
        taken = 0; done_cnt = 0; cycles = 0;
        stall_cnt = 0; stall_done = 0; gaps = 0; rmode = 0;
    endtask

    task automatic end_scn(input string tag, input int exp_win, input int exp_done);
        idle(4);
        check({tag, "_windows"}, 72'(taken), 72'(exp_win));
        check({tag, "_frame_done"}, 72'(done_cnt), 72'(exp_done));
    endtask

    initial begin
        #2;
        @(posedge clk); #1;
        check("reset_win_small", win_s, 72'd0);
        check("reset_win_big", win_b, 72'd0);
        check("reset_valid", 72'({wv_s, wv_b, fd_s, fd_b}), 72'd0);

        // Basic 4x4 frame, continuous ready
        start_scn(1'b0);
        for (int p = 0; p < 16; p++) push_pixel(8'(p));
        check("basic_cycles", 72'(cycles), 72'd16);
        end_scn("basic", 4, 1);

        // Back-pressure: 5-cycle stall on the first window
        start_scn(1'b0);
        rmode = 2;
        for (int p = 0; p < 16; p++) push_pixel(8'(p));
        check("stall_cycles", 72'(stall_cnt), 72'd5);
        end_scn("backpressure", 4, 1);

        // Full-throughput 16x16 frame
        start_scn(1'b1);
        for (int p = 0; p < 256; p++) push_pixel(8'(p));
        check("full_cycles", 72'(cycles), 72'd256);
        end_scn("full", 196, 1);

        // Two back-to-back 4x4 frames
        start_scn(1'b0);
        for (int p = 0; p < 32; p++) push_pixel(8'(p % 16));
        end_scn("two_frames", 8, 2);

        // Mid-frame clear, with a pixel offered during clear
        start_scn(1'b0);
        for (int p = 0; p < 9; p++) push_pixel(8'(p + 100));
        pixel = 8'd77;
        pvalid = 1'b1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        for (int p = 0; p < 16; p++) push_pixel(8'(p));
        end_scn("clear", 4, 1);

        // Async reset while a window is pending, then a fresh frame
        start_scn(1'b0);
        for (int p = 0; p < 11; p++) push_pixel(8'(p));
        pvalid = 1'b0;
        check("pre_reset_valid", 72'(wv_s), 72'd1);
        #2;
        nreset = 1'b0;
        #1;
        check("async_valid", 72'(wv_s), 72'd0);
        check("async_window", win_s, 72'd0);
        @(negedge clk);
        @(posedge clk); #1;
        nreset = 1'b1;
        taken = 0; done_cnt = 0;
        for (int p = 0; p < 16; p++) push_pixel(8'(p));
        end_scn("after_reset", 4, 1);

        // Random pixels, random input gaps and random consumer ready, 16x16
        start_scn(1'b1);
        gaps = 1;
        rmode = 1;
        for (int p = 0; p < 256; p++) push_pixel(8'($urandom_range(0, 255)));
        end_scn("random", 196, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
